// File: rtl/step_sequencer_pkg.sv
// Shared CNC definitions: sequencer FSM encoding and direction constants.
package step_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_WAIT  = 2'd3
    } seq_state_t;

    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;

endpackage

// File: rtl/step_sequencer.sv
// Step/dir segment sequencer: emits cmd_steps step pulses at a fixed period
// and tracks a signed position. The step and dir outputs drive an external step_dir stage.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | ready for a segment command
//   ST_SETUP | dir just changed, holding off step for DIR_SETUP cycles
//   ST_PULSE | step high for PULSE_TICKS cycles
//   ST_WAIT  | step low, waiting out the rest of the step period
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int STEPS_W     = 32,
    parameter int PERIOD_W    = 32,
    parameter int POS_W       = 32,
    parameter int PULSE_TICKS = 10,
    parameter int DIR_SETUP   = 5
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                sclr,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [STEPS_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                pos_set,
    input  logic [POS_W-1:0]    pos_value,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [POS_W-1:0]    position
);

    localparam int HOLD_W  = $clog2(PULSE_TICKS + 1);
    localparam int SETUP_W = $clog2(DIR_SETUP + 1);
    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(PULSE_TICKS + 1);

    seq_state_t          r_state;
    logic [STEPS_W-1:0]  r_steps_left;
    logic [PERIOD_W-1:0] r_peff;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [SETUP_W-1:0]  r_setup_cnt;
    logic                r_step;
    logic                r_dir;
    logic                r_done;
    logic                r_aborted;
    logic [POS_W-1:0]    r_position;

    logic                w_accept;
    logic                w_rise;
    logic [PERIOD_W-1:0] w_peff_cmd;
    logic [PERIOD_W-1:0] w_rise_peff;
    logic [STEPS_W-1:0]  w_steps_base;
    logic [POS_W-1:0]    w_pos_base;
    logic [POS_W-1:0]    w_pos_next;

    assign cmd_ready = (r_state == ST_IDLE) && !sclr;
    assign w_accept  = cmd_valid && cmd_ready;

    // The period can never be shorter than the pulse plus one low cycle.
    assign w_peff_cmd = (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;

    // A step rising edge starts straight from IDLE (no dir change), at the end
    // of SETUP, or at the end of a WAIT with steps remaining.
    assign w_rise = !sclr &&
                    ((w_accept && (cmd_steps != '0) && (cmd_dir == r_dir)) ||
                     ((r_state == ST_SETUP) && (r_setup_cnt == '0)) ||
                     ((r_state == ST_WAIT) && (r_period_cnt == '0) && (r_steps_left != '0)));

    assign w_rise_peff  = (r_state == ST_IDLE) ? w_peff_cmd : r_peff;
    assign w_steps_base = (r_state == ST_IDLE) ? cmd_steps : r_steps_left;

    // A load coinciding with a step still counts that step.
    assign w_pos_base = pos_set ? pos_value : r_position;
    assign w_pos_next = !w_rise          ? w_pos_base :
                        (r_dir == REV)   ? w_pos_base - POS_W'(1) :
                                           w_pos_base + POS_W'(1);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state      <= ST_IDLE;
            r_steps_left <= '0;
            r_peff       <= '0;
            r_period_cnt <= '0;
            r_hold_cnt   <= '0;
            r_setup_cnt  <= '0;
            r_step       <= 1'b0;
            r_dir        <= FWD;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_position   <= '0;
        end else begin
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_position <= w_pos_next;

            if (sclr) begin
                r_state   <= ST_IDLE;
                r_step    <= 1'b0;
                r_aborted <= (r_state != ST_IDLE);
            end else if (w_rise) begin
                r_state      <= ST_PULSE;
                r_step       <= 1'b1;
                r_hold_cnt   <= HOLD_W'(PULSE_TICKS - 1);
                r_peff       <= w_rise_peff;
                r_period_cnt <= w_rise_peff - PERIOD_W'(1);
                r_steps_left <= w_steps_base - STEPS_W'(1);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            if (cmd_steps == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_dir        <= cmd_dir;
                                r_state      <= ST_SETUP;
                                r_setup_cnt  <= SETUP_W'(DIR_SETUP - 1);
                                r_steps_left <= cmd_steps;
                                r_peff       <= w_peff_cmd;
                            end
                        end
                    end
                    ST_SETUP: begin
                        r_setup_cnt <= r_setup_cnt - SETUP_W'(1);
                    end
                    ST_PULSE: begin
                        r_period_cnt <= r_period_cnt - PERIOD_W'(1);
                        if (r_hold_cnt == '0) begin
                            r_step  <= 1'b0;
                            r_state <= ST_WAIT;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                        end
                    end
                    ST_WAIT: begin
                        if (r_period_cnt == '0) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_period_cnt <= r_period_cnt - PERIOD_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign step     = r_step;
    assign dir      = r_dir;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;
    assign aborted  = r_aborted;
    assign position = r_position;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed and random segments checked cycle by cycle
// against a timing model derived from segment start, period and step count.
module tb_step_sequencer;

    localparam int SW = 8;
    localparam int PW = 8;
    localparam int QW = 16;
    localparam int PT = 4;
    localparam int DS = 3;

    logic          clk = 1'b0;
    logic          aclr = 1'b1;
    logic          sclr = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
    logic [PW-1:0] cmd_period = '0;
    logic          pos_set = 1'b0;
    logic [QW-1:0] pos_value = '0;
    logic          cmd_ready, step, dir, busy, done, aborted;
    logic [QW-1:0] position;

    int n_checks = 0;
    int n_pass   = 0;

    logic          m_dir = 1'b0;
    logic [QW-1:0] m_pos = '0;

    step_sequencer #(
        .STEPS_W(SW), .PERIOD_W(PW), .POS_W(QW), .PULSE_TICKS(PT), .DIR_SETUP(DS)
    ) dut (
        .clk(clk), .aclr(aclr), .sclr(sclr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .pos_set(pos_set), .pos_value(pos_value),
        .step(step), .dir(dir), .busy(busy), .done(done), .aborted(aborted),
        .position(position)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input bit e_step, input bit e_busy,
                             input bit e_done, input bit e_ab, input bit e_ready);
        chk({tag, ".step"},     64'(step),      64'(e_step));
        chk({tag, ".dir"},      64'(dir),       64'(m_dir));
        chk({tag, ".busy"},     64'(busy),      64'(e_busy));
        chk({tag, ".done"},     64'(done),      64'(e_done));
        chk({tag, ".aborted"},  64'(aborted),   64'(e_ab));
        chk({tag, ".ready"},    64'(cmd_ready), 64'(e_ready));
        chk({tag, ".position"}, 64'(position),  64'(m_pos));
    endtask

    function automatic int peff_of(input int period);
        return (period < PT + 1) ? PT + 1 : period;
    endfunction

    function automatic int start_of(input bit d, input int steps);
        return 1 + (((steps != 0) && (d != m_dir)) ? DS : 0);
    endfunction

    // Cycle (relative to the handshake cycle) in which done is expected.
    function automatic int seg_len(input bit d, input int steps, input int period);
        return (steps == 0) ? 1 : start_of(d, steps) + steps * peff_of(period);
    endfunction

    // ab_k: cycle during which sclr is held (0 = none); load_k: edge at which pos_set lands.
    task automatic run_seg(input string tag, input bit d, input int steps, input int period,
                           input int ab_k, input int load_k, input logic [QW-1:0] load_v);
        int  peff, start, end_k, idx;
        bit  abt, rise, e_step, e_busy, e_done;
        peff  = peff_of(period);
        start = start_of(d, steps);
        end_k = seg_len(d, steps, period);
        chk({tag, ".ready_at_T"}, 64'(cmd_ready), 64'(1));
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_steps  = SW'(steps);
        cmd_period = PW'(period);
        sclr       = 1'b0;
        pos_set    = (load_k == 1);
        pos_value  = load_v;
        for (int k = 1; k <= end_k; k++) begin
            tick();
            cmd_valid  = 1'b0;
            cmd_dir    = 1'($urandom);
            cmd_steps  = SW'($urandom);
            cmd_period = PW'($urandom);
            sclr       = 1'b0;
            pos_set    = 1'b0;
            #1;
            abt = (ab_k != 0) && (k == ab_k + 1);
            if (k == 1 && steps != 0) m_dir = d;
            idx  = k - start;
            rise = !abt && (idx >= 0) && ((idx % peff) == 0) && ((idx / peff) < steps);
            if (k == load_k) m_pos = load_v;
            if (rise) m_pos = m_dir ? m_pos - QW'(1) : m_pos + QW'(1);
            e_step = !abt && (idx >= 0) && ((idx % peff) < PT) && (k < end_k);
            e_busy = !abt && (k < end_k);
            e_done = !abt && (k == end_k);
            check_all($sformatf("%s.c%0d", tag, k), e_step, e_busy, e_done, abt, !e_busy);
            if (abt) break;
            sclr      = (k == ab_k);
            pos_set   = (k + 1 == load_k);
            pos_value = load_v;
        end
        tick();
        sclr    = 1'b0;
        pos_set = 1'b0;
        #1;
        check_all({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle_load(input logic [QW-1:0] v);
        pos_set   = 1'b1;
        pos_value = v;
        tick();
        pos_set = 1'b0;
        m_pos   = v;
        #1;
        chk("idle_load", 64'(position), 64'(v));
    endtask

    initial begin
        int d, steps, period, len, ab_k, load_k;
        #2;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #10 aclr = 1'b0;
        tick();

        run_seg("fwd3",     1'b0, 3, 10, 0, 0, '0);
        idle_load('0);
        run_seg("dirchg",   1'b1, 2, 8, 0, 0, '0);
        run_seg("clamp",    1'b1, 3, 2, 0, 0, '0);
        run_seg("zero",     1'b0, 0, 7, 0, 0, '0);
        run_seg("abort",    1'b1, 5, 10, 11, 0, '0);
        run_seg("posload",  1'b0, 2, 6, 0, 4, QW'(100));
        idle_load(16'hFFFF);
        run_seg("wrap",     1'b0, 2, 5, 0, 0, '0);

        sclr = 1'b1;
        #1 chk("sclr_idle.ready", 64'(cmd_ready), 64'(0));
        tick();
        sclr = 1'b0;
        #1 check_all("sclr_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            d      = int'($urandom_range(0, 1));
            steps  = int'($urandom_range(0, 5));
            period = int'($urandom_range(1, 12));
            len    = seg_len(d[0], steps, period);
            ab_k   = (steps != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
            load_k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
            run_seg($sformatf("rnd%0d", i), d[0], steps, period, ab_k, load_k, QW'($urandom));
        end

        cmd_valid  = 1'b1;
        cmd_dir    = ~m_dir;
        cmd_steps  = SW'(4);
        cmd_period = PW'(6);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 aclr = 1'b1;
        m_dir = 1'b0;
        m_pos = '0;
        #1 check_all("aclr_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        #3 aclr = 1'b0;
        tick();
        check_all("aclr_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEPS_W, default 32: width of the segment step count.
REQ-002 SHALL have parameter PERIOD_W, default 32: width of the step period in clk cycles.
REQ-003 SHALL have parameter POS_W, default 32: width of the signed position counter.
REQ-004 SHALL have parameter PULSE_TICKS, default 10: step high time in clk cycles, minimum 1.
REQ-005 SHALL have parameter DIR_SETUP, default 5: dir-to-step setup in clk cycles, minimum 1.
REQ-006 SHALL have ports, one per line:
  clk  in  1  clock
  aclr  in  1  reset, asynchronous, active-high
  sclr  in  1  synchronous abort
  cmd_valid  in  1  segment command valid
  cmd_ready  out  1  segment command accepted when high with cmd_valid
  cmd_dir  in  1  direction: 0 forward (+1), 1 reverse (-1)
  cmd_steps  in  STEPS_W  number of steps, unsigned
  cmd_period  in  PERIOD_W  cycles between step rising edges, unsigned
  pos_set  in  1  load position
  pos_value  in  POS_W  position load value, signed
  step  out  1  registered step pulse, feeds the step_dir phase generator
  dir  out  1  registered direction
  busy  out  1  segment in progress
  done  out  1  one-cycle pulse, segment completed
  aborted  out  1  one-cycle pulse, segment killed by sclr
  position  out  POS_W  signed step position

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, PULSE, WAIT.
REQ-008 cmd_ready SHALL equal (state==IDLE) && !sclr; a command is accepted on a clk edge with cmd_valid && cmd_ready.
REQ-009 On acceptance with cmd_steps==0, the block SHALL pulse done in the next cycle, stay IDLE, and leave step, dir and position unchanged.
REQ-010 On acceptance with cmd_dir != dir, the block SHALL update dir at the next edge and enter SETUP for DIR_SETUP cycles, after which step rises.
REQ-011 On acceptance with cmd_dir == dir, the block SHALL go directly to PULSE, with step high from the next edge.
REQ-012 In PULSE, step SHALL remain high for exactly PULSE_TICKS cycles, then the FSM enters WAIT with step low.
REQ-013 Consecutive step rising edges SHALL be spaced exactly Peff = max(cmd_period, PULSE_TICKS+1) cycles.
REQ-014 position SHALL change by +1 (dir=0) or -1 (dir=1) in the cycle step rises, wrapping modulo 2^POS_W.
REQ-015 After the last step, WAIT SHALL last until Peff cycles have elapsed since its rising edge; the FSM then pulses done and returns to IDLE. The minimum gap between segments is one IDLE cycle.
REQ-016 busy SHALL be high in SETUP, PULSE and WAIT, and low in IDLE.
REQ-017 dir SHALL change only on command acceptance, never within a segment.
REQ-018 On sclr in any state, the block SHALL do all of the following at the next edge:
  - force step low and enter IDLE;
  - keep position and dir;
  - pulse aborted if busy was high, with no done pulse.
REQ-019 On pos_set, position SHALL load pos_value. If pos_set coincides with a step rising edge, position SHALL be pos_value±1 so that no step is lost.
REQ-020 cmd_dir, cmd_steps and cmd_period SHALL be latched at acceptance; input changes during a segment are ignored.

Reset
REQ-021 On aclr, the block SHALL reset to: state IDLE; step, done, aborted and busy 0; dir 0; position 0; all internal counters 0.
REQ-022 aclr asserted mid-segment SHALL terminate the segment immediately, with no done or aborted pulse.

Structure
REQ-023 The FSM state enum SHALL live in the shared CNC package, together with the direction constants FWD=0 and REV=1.
REQ-024 The implementation SHALL be one module with no sub-modules; the step and dir outputs connect externally to step_dir.

Verification (PULSE_TICKS=4, DIR_SETUP=3, accept at edge T)
REQ-025 Forward segment, no direction change:
  - Stimulus: dir=0, steps=3, period=10.
  - Required response: step rises at T+1, T+11 and T+21, high 4 cycles each; position 0 then 3; done at T+31.
REQ-026 Direction change:
  - Stimulus: dir currently 0, command dir=1, steps=2, period=8.
  - Required response: dir=1 from T+1; step rises at T+4 and T+12; position -2.
REQ-027 Period clamp:
  - Stimulus: period=2, steps=3.
  - Required response: rising edges spaced 5 cycles.
REQ-028 Zero-step command:
  - Stimulus: steps=0.
  - Required response: done at T+1; no step; position unchanged; cmd_ready high at T+1.
REQ-029 Abort mid-segment:
  - Stimulus: steps=5, period=10, sclr asserted after the 2nd rising edge.
  - Required response: step low the next cycle; aborted pulses once; no done; position 2.
REQ-030 Position load coincident with a step:
  - Stimulus: pos_set with pos_value=100 on a dir=0 rising edge.
  - Required response: position 101.
